mem_ctrl: RTL and testbench

- Arbiter and sequencer for the single byte-wide RAM port shared by instruction fetch (IF) and load/store (MEM).
- Serialises word fetches and 1/2/4-byte loads/stores into per-byte RAM cycles and returns assembled little-endian data.
- Drives the IF and MEM stall requests into the pipeline stall bus.
- Sits between the IF/MEM stages and the top-level RAM/IO bus.

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/mem_ctrl_if.sv | 48 ++++
 rtl/mem_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial RAM port controller.
// Imported by mem_ctrl_if and mem_ctrl.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR,
        DONE
    } state_t;

    localparam logic [1:0] LEN_1B = 2'b00;
    localparam logic [1:0] LEN_2B = 2'b01;
    localparam logic [1:0] LEN_4B = 2'b10;

    // Address bits [17:16] equal to this select the IO window.
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // Length code 2'b11 is treated as a full word.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_1B:  return 3'd1;
            LEN_2B:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch, load/store and RAM-side signals of the shared RAM port controller.
// The slave modport is the controller; master is the pipeline/RAM side.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_done_o;
    logic [31:0]       if_data_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_len_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic              mem_done_o;
    logic [31:0]       mem_rdata_o;

    logic [7:0]        ram_din_i;
    logic [7:0]        ram_dout_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_o;

    logic              if_stall_req_o;
    logic              mem_stall_req_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  ram_din_i,
        output if_done_o, if_data_o,
        output mem_done_o, mem_rdata_o,
        output ram_dout_o, ram_addr_o, ram_wr_o,
        output if_stall_req_o, mem_stall_req_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output ram_din_i,
        input  if_done_o, if_data_o,
        input  mem_done_o, mem_rdata_o,
        input  ram_dout_o, ram_addr_o, ram_wr_o,
        input  if_stall_req_o, mem_stall_req_o
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbiter/sequencer for the byte-wide RAM port shared by fetch and load/store.
// Optional IO store throttling is enabled by defining MEM_CTRL_IO_THROTTLE_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic      clk_in,
    input  logic      rst_in,
`ifdef MEM_CTRL_IO_THROTTLE_EN
    input  logic      io_buffer_full_i,
`endif
    mem_ctrl_if.slave bus
);

    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

    state_t            state;
    state_t            state_next;

    logic [3:0]        cnt;
    logic [2:0]        nbytes;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic              if_done;
    logic              mem_done;
    logic [31:0]       if_data;
    logic [31:0]       mem_rdata;
    logic [31:0]       asm_q;
    logic [31:0]       wdata_q;

    logic              grant_mem;
    logic              grant_if;
    logic              finish;
    logic              mem_ok;
    logic              capture;
    logic [1:0]        cap_idx;
    logic [1:0]        wr_idx;
    logic [3:0]        rd_last;
    logic [3:0]        wr_last;
    logic [31:0]       asm_next;

    // Read cycles run RD_LAT past the last address so the final byte lands.
    assign rd_last = 4'(nbytes) + RD_LAT_C - 4'd1;
    assign wr_last = 4'(nbytes) - 4'd1;
    assign capture = ((state == IF_RD) || (state == MEM_RD)) && (cnt >= RD_LAT_C);
    assign cap_idx = 2'(cnt - RD_LAT_C);
    assign wr_idx  = cnt[1:0] + 2'd1;

`ifdef MEM_CTRL_IO_THROTTLE_EN
    logic io_store;
    logic io_gap;

    assign io_store = bus.mem_we_i && (bus.mem_addr_i[17:16] == IO_ADDR_HI);
    assign mem_ok   = !(io_store && (io_buffer_full_i || io_gap));

    // Set by an IO store grant; the first IDLE cycle afterwards blocks and clears it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            io_gap <= 1'b0;
        end else if (grant_mem && io_store) begin
            io_gap <= 1'b1;
        end else if (state == IDLE) begin
            io_gap <= 1'b0;
        end
    end
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        asm_next = asm_q;
        if (capture) begin
            asm_next[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_req_i && mem_ok) begin
                    grant_mem  = 1'b1;
                    state_next = bus.mem_we_i ? MEM_WR : MEM_RD;
                end else if (bus.if_req_i && !bus.if_flush_i) begin
                    grant_if   = 1'b1;
                    state_next = IF_RD;
                end
            end
            IF_RD: begin
                if (bus.if_flush_i) begin
                    state_next = IDLE;
                end else if (cnt == rd_last) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            MEM_RD: begin
                if (cnt == rd_last) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            MEM_WR: begin
                if (cnt == wr_last) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt       <= '0;
            nbytes    <= '0;
            ram_addr  <= '0;
            ram_dout  <= '0;
            ram_wr    <= 1'b0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
            asm_q     <= '0;
            wdata_q   <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    asm_q <= '0;
                    if (grant_mem) begin
                        ram_addr <= bus.mem_addr_i;
                        nbytes   <= len_to_bytes(bus.mem_len_i);
                        wdata_q  <= bus.mem_wdata_i;
                        ram_dout <= bus.mem_wdata_i[7:0];
                        ram_wr   <= bus.mem_we_i;
                    end else if (grant_if) begin
                        ram_addr <= bus.if_addr_i;
                        nbytes   <= 3'd4;
                    end
                end
                IF_RD, MEM_RD: begin
                    cnt   <= cnt + 4'd1;
                    asm_q <= asm_next;
                    // Leaving on flush or completion parks the address at zero.
                    if (state_next != state) begin
                        ram_addr <= '0;
                    end else if ((cnt + 4'd1) < 4'(nbytes)) begin
                        ram_addr <= ram_addr + ADDR_W'(1);
                    end
                    if (finish) begin
                        if (state == IF_RD) begin
                            if_done <= 1'b1;
                            if_data <= asm_next;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= asm_next;
                        end
                    end
                end
                MEM_WR: begin
                    if (finish) begin
                        ram_wr   <= 1'b0;
                        ram_addr <= '0;
                        ram_dout <= '0;
                        mem_done <= 1'b1;
                    end else begin
                        cnt      <= cnt + 4'd1;
                        ram_addr <= ram_addr + ADDR_W'(1);
                        ram_dout <= wdata_q[{wr_idx, 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_addr_o      = ram_addr;
    assign bus.ram_dout_o      = ram_dout;
    assign bus.ram_wr_o        = ram_wr;
    assign bus.if_done_o       = if_done;
    assign bus.if_data_o       = if_data;
    assign bus.mem_done_o      = mem_done;
    assign bus.mem_rdata_o     = mem_rdata;
    assign bus.if_stall_req_o  = bus.if_req_i & ~if_done;
    assign bus.mem_stall_req_o = bus.mem_req_i & ~mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic
// against a byte-array RAM and an expected-memory model.
module tb_mem_ctrl;

    localparam int MW  = 18;
    localparam int MSZ = 1 << MW;

    logic clk_in = 1'b0;
    logic rst_in;

    always #5 clk_in = ~clk_in;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef MEM_CTRL_IO_THROTTLE_EN
    logic io_full;
`endif

    mem_ctrl #(.ADDR_W(32), .RD_LAT(1)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
`ifdef MEM_CTRL_IO_THROTTLE_EN
        .io_buffer_full_i (io_full),
`endif
        .bus              (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [7:0]  ram     [MSZ];
    logic [7:0]  ref_mem [MSZ];
    wr_t         wlog[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_if;
    logic [31:0] last_mem;

    // RAM model: one-cycle read latency, writes on the edge ending a ram_wr cycle.
    always @(posedge clk_in) begin
        bus.ram_din_i <= ram[bus.ram_addr_o[MW-1:0]];
        if (bus.ram_wr_o === 1'b1) begin
            ram[bus.ram_addr_o[MW-1:0]] <= bus.ram_dout_o;
            wlog.push_back(wr_t'({bus.ram_addr_o, bus.ram_dout_o}));
        end
    end

    function automatic int nb(input logic [1:0] len);
        if (len == 2'b00) return 1;
        if (len == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[MW'(a + 32'(k))];
        return r;
    endfunction

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(posedge clk_in); #1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = a;
        lat = -1;
        d   = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_in);
            if (bus.if_done_o === 1'b1) begin
                lat = n;
                d   = bus.if_data_o;
                break;
            end
        end
        @(posedge clk_in); #1;
        bus.if_req_i = 1'b0;
    endtask

    task automatic mem_op(input logic we, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        @(posedge clk_in); #1;
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_len_i   = len;
        bus.mem_addr_i  = a;
        bus.mem_wdata_i = wd;
        lat = -1;
        rd  = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_in);
            if (bus.mem_done_o === 1'b1) begin
                lat = n;
                rd  = bus.mem_rdata_o;
                break;
            end
        end
        @(posedge clk_in); #1;
        bus.mem_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        bus.if_req_i = 1'b0;  bus.if_addr_i = '0;  bus.if_flush_i = 1'b0;
        bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_len_i = '0;
        bus.mem_addr_i = '0;  bus.mem_wdata_i = '0;
        repeat (3) @(posedge clk_in);
        #1;
        n_cmp++; if (bus.ram_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_ram_addr: got %h want 0", bus.ram_addr_o); end
        n_cmp++; if (bus.ram_dout_o !== 8'h0) begin n_bad++; $display("FAIL reset_ram_dout: got %h want 0", bus.ram_dout_o); end
        n_cmp++; if (bus.ram_wr_o !== 1'b0) begin n_bad++; $display("FAIL reset_ram_wr: got %b want 0", bus.ram_wr_o); end
        n_cmp++; if (bus.if_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_if_done: got %b want 0", bus.if_done_o); end
        n_cmp++; if (bus.mem_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_mem_done: got %b want 0", bus.mem_done_o); end
        n_cmp++; if (bus.if_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_if_data: got %h want 0", bus.if_data_o); end
        n_cmp++; if (bus.mem_rdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_mem_rdata: got %h want 0", bus.mem_rdata_o); end
        n_cmp++; if ({bus.if_stall_req_o, bus.mem_stall_req_o} !== 2'b00) begin n_bad++; $display("FAIL reset_stalls: got %b want 00", {bus.if_stall_req_o, bus.mem_stall_req_o}); end
        rst_in = 1'b0;
        @(negedge clk_in);
        n_cmp++; if (bus.ram_wr_o !== 1'b0) begin n_bad++; $display("FAIL idle_ram_wr: got %b want 0", bus.ram_wr_o); end
        last_if  = '0;
        last_mem = '0;
    endtask

    task automatic test_fetch();
        ram[32'h1000] <= 8'h13; ram[32'h1001] <= 8'h05; ram[32'h1002] <= 8'h00; ram[32'h1003] <= 8'h00;
        ref_mem[32'h1000] = 8'h13; ref_mem[32'h1001] = 8'h05; ref_mem[32'h1002] = 8'h00; ref_mem[32'h1003] = 8'h00;
        @(posedge clk_in); #1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h1000;
        for (int n = 0; n <= 6; n++) begin
            @(negedge clk_in);
            if (n >= 1 && n <= 4) begin
                n_cmp++; if (bus.ram_addr_o !== 32'h1000 + 32'(n - 1)) begin n_bad++; $display("FAIL fetch_addr_c%0d: got %h want %h", n, bus.ram_addr_o, 32'h1000 + 32'(n - 1)); end
                n_cmp++; if (bus.ram_wr_o !== 1'b0) begin n_bad++; $display("FAIL fetch_wr_c%0d: got %b want 0", n, bus.ram_wr_o); end
            end
            n_cmp++; if (bus.if_done_o !== (n == 6)) begin n_bad++; $display("FAIL fetch_done_c%0d: got %b want %b", n, bus.if_done_o, (n == 6)); end
            n_cmp++; if (bus.if_stall_req_o !== (n != 6)) begin n_bad++; $display("FAIL fetch_stall_c%0d: got %b want %b", n, bus.if_stall_req_o, (n != 6)); end
        end
        n_cmp++; if (bus.if_data_o !== 32'h0000_0513) begin n_bad++; $display("FAIL fetch_data: got %h want 00000513", bus.if_data_o); end
        last_if = 32'h0000_0513;
        @(posedge clk_in); #1;
        bus.if_req_i = 1'b0;
    endtask

    task automatic test_contention();
        logic [31:0] exp_m;
        exp_m = ref_word(32'h2000, 4);
        @(posedge clk_in); #1;
        bus.mem_req_i  = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'b10; bus.mem_addr_i = 32'h2000;
        bus.if_req_i   = 1'b1; bus.if_addr_i = 32'h1000;
        for (int n = 0; n <= 13; n++) begin
            @(negedge clk_in);
            if (n <= 6) begin
                n_cmp++; if (bus.mem_done_o !== (n == 6)) begin n_bad++; $display("FAIL cont_mem_done_c%0d: got %b want %b", n, bus.mem_done_o, (n == 6)); end
            end
            if (n == 6) begin
                n_cmp++; if (bus.mem_rdata_o !== exp_m) begin n_bad++; $display("FAIL cont_mem_rdata: got %h want %h", bus.mem_rdata_o, exp_m); end
            end
            if (n <= 12) begin
                n_cmp++; if (bus.if_stall_req_o !== 1'b1) begin n_bad++; $display("FAIL cont_if_stall_c%0d: got %b want 1", n, bus.if_stall_req_o); end
                n_cmp++; if (bus.if_done_o !== 1'b0) begin n_bad++; $display("FAIL cont_if_early_c%0d: got %b want 0", n, bus.if_done_o); end
            end
            if (n == 8) begin
                n_cmp++; if (bus.ram_addr_o !== 32'h1000) begin n_bad++; $display("FAIL cont_if_grant_addr: got %h want 00001000", bus.ram_addr_o); end
            end
            if (n == 13) begin
                n_cmp++; if (bus.if_done_o !== 1'b1) begin n_bad++; $display("FAIL cont_if_done: got %b want 1", bus.if_done_o); end
                n_cmp++; if (bus.if_data_o !== ref_word(32'h1000, 4)) begin n_bad++; $display("FAIL cont_if_data: got %h want %h", bus.if_data_o, ref_word(32'h1000, 4)); end
            end
            if (n == 6) begin
                @(posedge clk_in); #1;
                bus.mem_req_i = 1'b0;
            end
        end
        last_mem = exp_m;
        last_if  = ref_word(32'h1000, 4);
        @(posedge clk_in); #1;
        bus.if_req_i = 1'b0;
    endtask

    task automatic test_store_byte();
        wlog.delete();
        @(posedge clk_in); #1;
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'b00;
        bus.mem_addr_i = 32'h3001; bus.mem_wdata_i = 32'h5A5A_5AAB;
        for (int n = 0; n <= 2; n++) begin
            @(negedge clk_in);
            n_cmp++; if (bus.ram_wr_o !== (n == 1)) begin n_bad++; $display("FAIL stb_wr_c%0d: got %b want %b", n, bus.ram_wr_o, (n == 1)); end
            n_cmp++; if (bus.mem_done_o !== (n == 2)) begin n_bad++; $display("FAIL stb_done_c%0d: got %b want %b", n, bus.mem_done_o, (n == 2)); end
            if (n == 1) begin
                n_cmp++; if (bus.ram_addr_o !== 32'h3001) begin n_bad++; $display("FAIL stb_addr: got %h want 00003001", bus.ram_addr_o); end
                n_cmp++; if (bus.ram_dout_o !== 8'hAB) begin n_bad++; $display("FAIL stb_dout: got %h want ab", bus.ram_dout_o); end
            end
            if (n == 2) begin
                n_cmp++; if (bus.ram_addr_o !== 32'h0) begin n_bad++; $display("FAIL stb_done_addr: got %h want 0", bus.ram_addr_o); end
            end
        end
        @(posedge clk_in); #1;
        bus.mem_req_i = 1'b0;
        ref_mem[32'h3001] = 8'hAB;
        repeat (3) @(negedge clk_in);
        n_cmp++; if (wlog.size() != 1) begin n_bad++; $display("FAIL stb_write_count: got %0d want 1", wlog.size()); end
    endtask

    task automatic test_flush();
        logic [31:0] exp_w;
        exp_w = ref_word(32'h2000, 4);
        @(posedge clk_in); #1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h1000;
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk_in);
            n_cmp++; if (bus.if_done_o !== (n == 10)) begin n_bad++; $display("FAIL flush_done_c%0d: got %b want %b", n, bus.if_done_o, (n == 10)); end
            if (n == 5) begin
                n_cmp++; if (bus.ram_addr_o !== 32'h2000) begin n_bad++; $display("FAIL flush_regrant_addr: got %h want 00002000", bus.ram_addr_o); end
            end
            if (n == 9) begin
                n_cmp++; if (bus.if_data_o !== last_if) begin n_bad++; $display("FAIL flush_data_hold: got %h want %h", bus.if_data_o, last_if); end
            end
            if (n == 10) begin
                n_cmp++; if (bus.if_data_o !== exp_w) begin n_bad++; $display("FAIL flush_new_data: got %h want %h", bus.if_data_o, exp_w); end
            end
            if (n == 2) begin
                @(posedge clk_in); #1;
                bus.if_flush_i = 1'b1;
            end else if (n == 3) begin
                @(posedge clk_in); #1;
                bus.if_flush_i = 1'b0;
                bus.if_addr_i  = 32'h2000;
            end
        end
        last_if = exp_w;
        @(posedge clk_in); #1;
        bus.if_req_i = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] w;
        int          done_seen;
        int          wr_seen;
        w = $urandom;
        wlog.delete();
        @(posedge clk_in); #1;
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'b10;
        bus.mem_addr_i = 32'h3100; bus.mem_wdata_i = w;
        @(negedge clk_in);
        @(negedge clk_in);
        n_cmp++; if (bus.ram_wr_o !== 1'b1) begin n_bad++; $display("FAIL rst_store_c1_wr: got %b want 1", bus.ram_wr_o); end
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        n_cmp++; if (bus.ram_wr_o !== 1'b0) begin n_bad++; $display("FAIL rst_store_wr: got %b want 0", bus.ram_wr_o); end
        n_cmp++; if (bus.ram_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_store_addr: got %h want 0", bus.ram_addr_o); end
        n_cmp++; if (bus.ram_dout_o !== 8'h0) begin n_bad++; $display("FAIL rst_store_dout: got %h want 0", bus.ram_dout_o); end
        n_cmp++; if ({bus.if_done_o, bus.mem_done_o} !== 2'b00) begin n_bad++; $display("FAIL rst_store_done: got %b want 00", {bus.if_done_o, bus.mem_done_o}); end
        n_cmp++; if ({bus.if_data_o, bus.mem_rdata_o} !== 64'h0) begin n_bad++; $display("FAIL rst_store_data: got %h want 0", {bus.if_data_o, bus.mem_rdata_o}); end
        bus.mem_req_i = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        done_seen = 0;
        wr_seen   = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_in);
            if (bus.mem_done_o === 1'b1) done_seen++;
            if (bus.ram_wr_o === 1'b1) wr_seen++;
        end
        n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL rst_store_no_done: got %0d pulses want 0", done_seen); end
        n_cmp++; if (wr_seen != 0) begin n_bad++; $display("FAIL rst_store_no_wr: got %0d cycles want 0", wr_seen); end
        n_cmp++; if (wlog.size() != 1) begin n_bad++; $display("FAIL rst_store_wlog: got %0d writes want 1", wlog.size()); end
        ref_mem[32'h3100] = w[7:0];
        last_if  = '0;
        last_mem = '0;
    endtask

`ifdef MEM_CTRL_IO_THROTTLE_EN
    task automatic test_io_throttle();
        @(posedge clk_in); #1;
        io_full = 1'b1;
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'b00;
        bus.mem_addr_i = 32'h3_0000; bus.mem_wdata_i = 32'h77;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_in);
            n_cmp++; if (bus.ram_wr_o !== 1'b0) begin n_bad++; $display("FAIL io_blocked_wr_c%0d: got %b want 0", n, bus.ram_wr_o); end
            n_cmp++; if (bus.mem_stall_req_o !== 1'b1) begin n_bad++; $display("FAIL io_blocked_stall_c%0d: got %b want 1", n, bus.mem_stall_req_o); end
        end
        @(posedge clk_in); #1;
        io_full = 1'b0;
        @(negedge clk_in);
        n_cmp++; if (bus.ram_wr_o !== 1'b0) begin n_bad++; $display("FAIL io_fall_wr: got %b want 0", bus.ram_wr_o); end
        @(negedge clk_in);
        n_cmp++; if ({bus.ram_wr_o, bus.ram_addr_o, bus.ram_dout_o} !== {1'b1, 32'h3_0000, 8'h77}) begin n_bad++; $display("FAIL io_write: got %b/%h/%h want 1/00030000/77", bus.ram_wr_o, bus.ram_addr_o, bus.ram_dout_o); end
        @(negedge clk_in);
        n_cmp++; if (bus.mem_done_o !== 1'b1) begin n_bad++; $display("FAIL io_done: got %b want 1", bus.mem_done_o); end
        @(posedge clk_in); #1;
        bus.mem_addr_i = 32'h3_0001; bus.mem_wdata_i = 32'h88;
        @(negedge clk_in);
        n_cmp++; if (bus.ram_wr_o !== 1'b0) begin n_bad++; $display("FAIL io_gap_wr_0: got %b want 0", bus.ram_wr_o); end
        @(negedge clk_in);
        n_cmp++; if (bus.ram_wr_o !== 1'b0) begin n_bad++; $display("FAIL io_gap_wr_1: got %b want 0", bus.ram_wr_o); end
        @(negedge clk_in);
        n_cmp++; if ({bus.ram_wr_o, bus.ram_addr_o} !== {1'b1, 32'h3_0001}) begin n_bad++; $display("FAIL io_second_write: got %b/%h want 1/00030001", bus.ram_wr_o, bus.ram_addr_o); end
        @(negedge clk_in);
        n_cmp++; if (bus.mem_done_o !== 1'b1) begin n_bad++; $display("FAIL io_second_done: got %b want 1", bus.mem_done_o); end
        @(posedge clk_in); #1;
        bus.mem_req_i = 1'b0;
        ref_mem[32'h3_0000] = 8'h77;
        ref_mem[32'h3_0001] = 8'h88;
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] d;
        logic [31:0] exp_d;
        logic [1:0]  len;
        int          kind;
        int          n;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            a    = 32'($urandom_range(0, MSZ - 8));
            len  = 2'($urandom_range(0, 3));
            w    = $urandom;
            n    = nb(len);
            if (kind == 0) begin
                exp_d = ref_word(a, 4);
                do_fetch(a, d, lat);
                n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL rnd%0d_fetch_lat: got %0d want 6", i, lat); end
                n_cmp++; if (d !== exp_d) begin n_bad++; $display("FAIL rnd%0d_fetch_data @%h: got %h want %h", i, a, d, exp_d); end
                n_cmp++; if (bus.mem_rdata_o !== last_mem) begin n_bad++; $display("FAIL rnd%0d_rdata_hold: got %h want %h", i, bus.mem_rdata_o, last_mem); end
                last_if = exp_d;
            end else if (kind == 1) begin
                exp_d = ref_word(a, n);
                mem_op(1'b0, len, a, w, d, lat);
                n_cmp++; if (lat != n + 2) begin n_bad++; $display("FAIL rnd%0d_load_lat: got %0d want %0d", i, lat, n + 2); end
                n_cmp++; if (d !== exp_d) begin n_bad++; $display("FAIL rnd%0d_load_data @%h len %0d: got %h want %h", i, a, n, d, exp_d); end
                n_cmp++; if (bus.if_data_o !== last_if) begin n_bad++; $display("FAIL rnd%0d_ifdata_hold: got %h want %h", i, bus.if_data_o, last_if); end
                last_mem = exp_d;
            end else begin
                wlog.delete();
                mem_op(1'b1, len, a, w, d, lat);
                n_cmp++; if (lat != n + 1) begin n_bad++; $display("FAIL rnd%0d_store_lat: got %0d want %0d", i, lat, n + 1); end
                n_cmp++; if (wlog.size() != n) begin n_bad++; $display("FAIL rnd%0d_store_count: got %0d want %0d", i, wlog.size(), n); end
                for (int k = 0; k < n && k < wlog.size(); k++) begin
                    n_cmp++;
                    if (wlog[k] !== wr_t'({a + 32'(k), w[8*k +: 8]})) begin
                        n_bad++;
                        $display("FAIL rnd%0d_store_byte%0d: got %h/%h want %h/%h", i, k, wlog[k].a, wlog[k].d, a + 32'(k), w[8*k +: 8]);
                    end
                end
                for (int k = 0; k < n; k++) ref_mem[MW'(a + 32'(k))] = w[8*k +: 8];
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < MSZ; i++) begin
            ref_mem[i] = 8'($urandom);
            ram[i]    <= ref_mem[i];
        end
`ifdef MEM_CTRL_IO_THROTTLE_EN
        io_full = 1'b0;
`endif
        test_reset();
        test_fetch();
        test_contention();
        test_store_byte();
        test_flush();
        test_reset_mid_store();
`ifdef MEM_CTRL_IO_THROTTLE_EN
        test_io_throttle();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
